// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared types and constants for the RTC parallel bus blocks
package rtc_pkg;

    localparam int RTC_DATA_W = 8;

    localparam logic [7:0] RTC_REG_SEC  = 8'h21;
    localparam logic [7:0] RTC_REG_MIN  = 8'h22;
    localparam logic [7:0] RTC_REG_HOUR = 8'h23;
    localparam logic [7:0] RTC_REG_DAY  = 8'h24;
    localparam logic [7:0] RTC_REG_MON  = 8'h25;
    localparam logic [7:0] RTC_REG_YEAR = 8'h26;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ADDR_SETUP  = 3'd1,
        ST_ADDR_STROBE = 3'd2,
        ST_ADDR_HOLD   = 3'd3,
        ST_DATA_SETUP  = 3'd4,
        ST_DATA_STROBE = 3'd5,
        ST_DATA_HOLD   = 3'd6,
        ST_GAP         = 3'd7
    } rtc_state_e;

    function automatic logic is_bcd_byte(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// rtl/rtc_bus_sequencer_if.sv - RTC multiplexed address/data pin bundle
interface rtc_bus_if #(
    parameter int DATA_W = 8
);
    logic              A_D;
    logic              CS;
    logic              RD;
    logic              WR;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic [DATA_W-1:0] bus_in;

    modport master (
        output A_D, CS, RD, WR, bus_out, bus_oe,
        input  bus_in
    );

    modport slave (
        input  A_D, CS, RD, WR, bus_out, bus_oe,
        output bus_in
    );
endinterface

// File: rtl/rtc_phase_timer.sv
// rtl/rtc_phase_timer.sv - free-running phase down-counter, reloads on load or at phase end
module rtc_phase_timer #(
    parameter int PHASE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    output logic o_phase_first,
    output logic o_phase_last
);
    localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(PHASE_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= RELOAD;
        end else if (i_load || (r_cnt == '0)) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_phase_first = (r_cnt == RELOAD);
    assign o_phase_last  = (r_cnt == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - single/burst RTC bus transaction sequencer
// Optional: RTC_BCD_CHECK_EN flags read bytes with a nibble above 9.
module rtc_bus_sequencer
    import rtc_pkg::*;
#(
    parameter int DATA_W       = RTC_DATA_W,
    parameter int PHASE_CYCLES = 4,
    parameter int MAX_BURST    = 16,
    parameter int CNT_W        = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              wr_nrd,
    input  logic [DATA_W-1:0] addr,
    input  logic [CNT_W-1:0]  count,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              bcd_err,
    rtc_bus_if.master         bus
);
    localparam logic [CNT_W-1:0] MAX_B = CNT_W'(MAX_BURST);

    rtc_state_e        r_state;
    rtc_state_e        w_next;
    logic              r_wr;
    logic [DATA_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_beats;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_done;

    logic              w_phase_first;
    logic              w_phase_last;
    logic [CNT_W-1:0]  w_count_clamped;
    logic              w_cs_n;
    logic              w_rd_n;
    logic              w_wr_n;
    logic              w_a_d;
    logic              w_oe;
    logic              w_pop;
    logic [DATA_W-1:0] w_bus_val;
    logic              w_rd_sample;

    assign w_count_clamped = (count > MAX_B) ? MAX_B : count;

    // Timer is held at reload while idle so the first bus phase gets full length.
    rtc_phase_timer #(
        .PHASE_CYCLES(PHASE_CYCLES)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_load       (r_state == ST_IDLE),
        .o_phase_first(w_phase_first),
        .o_phase_last (w_phase_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cs_n    = 1'b1;
        w_rd_n    = 1'b1;
        w_wr_n    = 1'b1;
        w_a_d     = 1'b1;
        w_oe      = 1'b0;
        w_pop     = 1'b0;
        w_bus_val = r_addr;
        case (r_state)
            ST_IDLE: begin
                if (start && (w_count_clamped != '0)) w_next = ST_ADDR_SETUP;
            end
            ST_ADDR_SETUP: begin
                w_cs_n = 1'b0;
                w_a_d  = 1'b0;
                w_oe   = 1'b1;
                if (w_phase_last) w_next = ST_ADDR_STROBE;
            end
            ST_ADDR_STROBE: begin
                w_cs_n = 1'b0;
                w_a_d  = 1'b0;
                w_oe   = 1'b1;
                w_wr_n = 1'b0;
                if (w_phase_last) w_next = ST_ADDR_HOLD;
            end
            ST_ADDR_HOLD: begin
                w_cs_n = 1'b0;
                w_a_d  = 1'b0;
                w_oe   = 1'b1;
                if (w_phase_last) w_next = ST_DATA_SETUP;
            end
            ST_DATA_SETUP: begin
                w_cs_n    = 1'b0;
                w_oe      = r_wr;
                w_pop     = r_wr && w_phase_first;
                // Source word goes straight to the pins while it is being captured.
                w_bus_val = w_pop ? wr_data : r_wdata;
                if (w_phase_last) w_next = ST_DATA_STROBE;
            end
            ST_DATA_STROBE: begin
                w_cs_n    = 1'b0;
                w_oe      = r_wr;
                w_bus_val = r_wdata;
                w_wr_n    = ~r_wr;
                w_rd_n    = r_wr;
                if (w_phase_last) w_next = ST_DATA_HOLD;
            end
            ST_DATA_HOLD: begin
                w_cs_n    = 1'b0;
                w_oe      = r_wr;
                w_bus_val = r_wdata;
                if (w_phase_last) w_next = ST_GAP;
            end
            ST_GAP: begin
                if (w_phase_last) w_next = (r_beats > CNT_W'(1)) ? ST_ADDR_SETUP : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_rd_sample = (r_state == ST_DATA_STROBE) && w_phase_last && !r_wr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_beats    <= '0;
            r_wdata    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            if ((r_state == ST_IDLE) && start) begin
                r_wr    <= wr_nrd;
                r_addr  <= addr;
                r_beats <= w_count_clamped;
                r_done  <= (w_count_clamped == '0);
            end
            if (w_pop) r_wdata <= wr_data;
            if (w_rd_sample) begin
                r_rd_data  <= bus.bus_in;
                r_rd_valid <= 1'b1;
            end
            if ((r_state == ST_GAP) && w_phase_last) begin
                if (r_beats > CNT_W'(1)) begin
                    r_beats <= r_beats - CNT_W'(1);
                    r_addr  <= r_addr + DATA_W'(1);
                end else begin
                    r_done <= 1'b1;
                end
            end
        end
    end

`ifdef RTC_BCD_CHECK_EN
    logic r_bcd_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bcd_err <= 1'b0;
        end else begin
            r_bcd_err <= w_rd_sample && !is_bcd_byte(bus.bus_in[7:0]);
        end
    end

    assign bcd_err = r_bcd_err;
`else
    assign bcd_err = 1'b0;
`endif

    assign wr_pop      = w_pop;
    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign bus.CS      = w_cs_n;
    assign bus.RD      = w_rd_n;
    assign bus.WR      = w_wr_n;
    assign bus.A_D     = w_a_d;
    assign bus.bus_oe  = w_oe;
    assign bus.bus_out = w_oe ? w_bus_val : '0;

endmodule
